branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch decision logic.
- Resolves a branch from ALU flags with an extended branch-type set.
- Also keeps a direct-mapped table of 2-bit saturating counters, indexed by PC, to predict taken/not-taken at fetch.
- Sits between IF (prediction lookup) and EX (resolution, mispredict flag, table update) of the pipelined CPU.

Parameters:
- PC_W, 32: width of PC inputs.
- IDX_W, 6: table index width; DEPTH = 2**IDX_W entries; index = pc[IDX_W+1:2].
- CNT_INIT, 2'b01: counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- pred_valid_i, input, 1: IF requests a prediction this cycle.
- pred_pc_i, input, PC_W: PC of the fetched instruction.
- pred_taken_o, output, 1: registered prediction, 1 = predict taken.
- pred_valid_o, output, 1: registered; pred_taken_o is meaningful.
- res_valid_i, input, 1: EX presents a resolving instruction this cycle.
- res_pc_i, input, PC_W: PC of the resolving instruction.
- branchType_i, input, 3: branch type code (see Behaviour).
- zero_i, input, 1: ALU zero flag.
- resultBit31_i, input, 1: ALU result sign bit.
- pred_taken_i, input, 1: prediction originally issued for this instruction, carried down the pipeline.
- branch_o, output, 1: registered actual-taken decision.
- mispredict_o, output, 1: registered; actual decision differs from pred_taken_i.

Behaviour:
- Clock and reset: one clock domain on clk_i; rst_i is synchronous and active-high.
- Reset (rst_i=1 at a rising edge):
  - all DEPTH counters <= CNT_INIT.
  - pred_taken_o, pred_valid_o, branch_o, mispredict_o <= 0.
  - Reset takes priority over every simultaneous request. No table write occurs in a reset cycle.
- Branch types and taken condition:
  - 000: none.
  - 001 beq: zero_i.
  - 010 bne/bnez: !zero_i.
  - 011 ble: zero_i | resultBit31_i.
  - 100 bltz: resultBit31_i.
  - 101 bgt: !zero_i & !resultBit31_i.
  - 110 bge: !resultBit31_i.
  - 111: reserved, treated as none.
- Prediction, latency 1:
  - When pred_valid_i=1 at edge N, at N+1: pred_valid_o=1 and pred_taken_o = counter[idx(pred_pc_i)][1].
  - When pred_valid_i=0: pred_valid_o=0 and pred_taken_o holds its previous value.
- Resolution, latency 1. When res_valid_i=1 at edge N with a branch type (001..110), at N+1:
  - branch_o = taken condition.
  - mispredict_o = branch_o ^ pred_taken_i.
  - counter[idx(res_pc_i)] is updated at edge N.
- Non-branch resolution: res_valid_i=0, or type 000/111, gives branch_o=0 and mispredict_o=0 at N+1, with no table update.
- Counter update: saturating. Taken increments, stopping at 2'b11. Not-taken decrements, stopping at 2'b00. No wrap-around in either direction.
- Same-index collision: a prediction and an update to the same index in the same cycle return the pre-update counter value (no bypass). The update still commits.
- Index aliasing: PCs that differ only above bit IDX_W+1 share an entry. This is expected and is not detected.
- Prediction and resolution ports are fully independent. Both may be active every cycle with no backpressure and no stall output.

Optional Feature:
- Macro: BPU_STATS_EN.
- When defined, two extra outputs are added:
  - branch_cnt_o[31:0]: counts resolved branches (types 001..110 with res_valid_i=1).
  - miss_cnt_o[31:0]: counts resolved branches with a mispredict.
- Both counters are updated on the same edge as the table. They saturate at 32'hFFFFFFFF and reset to 0 on rst_i.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset check: assert rst_i one cycle, then predict at PCs 0x0, 0x4, 0xFC -> pred_valid_o=1 and pred_taken_o=0 one cycle later for every entry (CNT_INIT=01).
- Counter saturation: resolve beq at PC 0x40 with zero_i=1 four times, then predict 0x40 -> counter saturates at 11, pred_taken_o=1. Then resolve not-taken twice -> 01, pred_taken_o=0. Two more not-taken -> stays at 00, no wrap.
- Branch-type truth table: sweep all 8 types × {zero_i, resultBit31_i} combinations with pred_taken_i=0 -> branch_o matches the table one cycle later; types 000/111 give branch_o=0 and no table change. Example: ble with zero_i=0, resultBit31_i=1 -> branch_o=1.
- Mispredict flag: resolve bne with zero_i=1 and pred_taken_i=1 -> branch_o=0, mispredict_o=1. Then bltz with resultBit31_i=1 and pred_taken_i=1 -> mispredict_o=0.
- Same-index collision: with entry 0x10 at 01, predict 0x10 and resolve taken at 0x10 in the same cycle -> pred_taken_o=0 (old value). Predict again next cycle -> pred_taken_o=1.
- Reset mid-stream: assert rst_i while res_valid_i=1 (taken) and pred_valid_i=1 -> next cycle all outputs are 0 and the entry reads CNT_INIT. With BPU_STATS_EN, after 3 resolves with 1 mispredict -> branch_cnt_o=3, miss_cnt_o=1, and both are 0 after reset.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Bundles the IF prediction port and the EX resolution port of branch_predict_unit.
// The statistics outputs exist only when BPU_STATS_EN is defined.
interface branch_predict_unit_if #(
  parameter int PC_W = 32
);
  logic            pred_valid_i;
  logic [PC_W-1:0] pred_pc_i;
  logic            pred_taken_o;
  logic            pred_valid_o;
  logic            res_valid_i;
  logic [PC_W-1:0] res_pc_i;
  logic [2:0]      branchType_i;
  logic            zero_i;
  logic            resultBit31_i;
  logic            pred_taken_i;
  logic            branch_o;
  logic            mispredict_o;
`ifdef BPU_STATS_EN
  logic [31:0]     branch_cnt_o;
  logic [31:0]     miss_cnt_o;
`endif

  modport master (
    output pred_valid_i, pred_pc_i, res_valid_i, res_pc_i, branchType_i,
           zero_i, resultBit31_i, pred_taken_i,
`ifdef BPU_STATS_EN
    input  branch_cnt_o, miss_cnt_o,
`endif
    input  pred_taken_o, pred_valid_o, branch_o, mispredict_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, res_valid_i, res_pc_i, branchType_i,
           zero_i, resultBit31_i, pred_taken_i,
`ifdef BPU_STATS_EN
    output branch_cnt_o, miss_cnt_o,
`endif
    output pred_taken_o, pred_valid_o, branch_o, mispredict_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution from ALU flags plus a PC-indexed table of 2-bit saturating counters.
// Define BPU_STATS_EN to add saturating resolved-branch and mispredict counters.
module branch_predict_unit #(
  parameter int          PC_W     = 32,
  parameter int          IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input logic                  clk_i,
  input logic                  rst_i,
  branch_predict_unit_if.slave bus
);
  localparam int DEPTH = 2**IDX_W;

  logic [1:0]       cnt_tbl [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             is_branch;
  logic             actual_taken;
  logic             do_update;
  logic [1:0]       res_cnt;
  logic [1:0]       res_cnt_next;
  logic             pred_taken_q;
  logic             pred_valid_q;
  logic             branch_q;
  logic             mispredict_q;

  // PC bits outside the index field are deliberately ignored (aliasing is accepted).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc_i[PC_W-1:IDX_W+2], bus.pred_pc_i[1:0],
                            bus.res_pc_i[PC_W-1:IDX_W+2], bus.res_pc_i[1:0]};

  assign pred_idx = bus.pred_pc_i[IDX_W+1:2];
  assign res_idx  = bus.res_pc_i[IDX_W+1:2];

  always_comb begin
    is_branch    = 1'b1;
    actual_taken = 1'b0;
    case (bus.branchType_i)
      3'b001:  actual_taken = bus.zero_i;
      3'b010:  actual_taken = !bus.zero_i;
      3'b011:  actual_taken = bus.zero_i | bus.resultBit31_i;
      3'b100:  actual_taken = bus.resultBit31_i;
      3'b101:  actual_taken = !bus.zero_i & !bus.resultBit31_i;
      3'b110:  actual_taken = !bus.resultBit31_i;
      default: is_branch = 1'b0;
    endcase
  end

  assign do_update = bus.res_valid_i & is_branch;
  assign res_cnt   = cnt_tbl[res_idx];

  always_comb begin
    res_cnt_next = res_cnt;
    if (actual_taken && res_cnt != 2'b11)
      res_cnt_next = res_cnt + 2'b01;
    else if (!actual_taken && res_cnt != 2'b00)
      res_cnt_next = res_cnt - 2'b01;
  end

  // Prediction reads the pre-update value on a same-index collision; no bypass.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_tbl[i] <= CNT_INIT;
      pred_taken_q <= 1'b0;
      pred_valid_q <= 1'b0;
      branch_q     <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      pred_valid_q <= bus.pred_valid_i;
      if (bus.pred_valid_i)
        pred_taken_q <= cnt_tbl[pred_idx][1];
      branch_q     <= do_update & actual_taken;
      mispredict_q <= do_update & (actual_taken ^ bus.pred_taken_i);
      if (do_update)
        cnt_tbl[res_idx] <= res_cnt_next;
    end
  end

  assign bus.pred_taken_o = pred_taken_q;
  assign bus.pred_valid_o = pred_valid_q;
  assign bus.branch_o     = branch_q;
  assign bus.mispredict_o = mispredict_q;

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (do_update) begin
      if (branch_cnt_q != '1)
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if ((actual_taken ^ bus.pred_taken_i) && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.branch_cnt_o = branch_cnt_q;
  assign bus.miss_cnt_o   = miss_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a behavioural table model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(32)) bus ();

  branch_predict_unit #(.PC_W(32), .IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  int       m_tbl [64];
  bit       m_ready = 0;
  logic     e_pv, e_pt, e_br, e_mp;
  longint   e_bc, e_mc;

  function automatic bit spec_taken(input logic [2:0] t, input logic z, input logic n);
    case (t)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return z || n;
      3'd4:    return n;
      3'd5:    return !z && !n;
      3'd6:    return !n;
      default: return 0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_tbl[i]) m_tbl[i] = 1;
      e_pv = 0; e_pt = 0; e_br = 0; e_mp = 0; e_bc = 0; e_mc = 0;
      m_ready = 1;
    end else begin
      bit br, act;
      int ri;
      e_pv = bus.pred_valid_i;
      if (bus.pred_valid_i) e_pt = (m_tbl[idx_of(bus.pred_pc_i)] >= 2);
      br  = bus.res_valid_i && bus.branchType_i >= 3'd1 && bus.branchType_i <= 3'd6;
      act = spec_taken(bus.branchType_i, bus.zero_i, bus.resultBit31_i);
      e_br = br && act;
      e_mp = br && (act != bus.pred_taken_i);
      if (br) begin
        ri = idx_of(bus.res_pc_i);
        m_tbl[ri] = act ? ((m_tbl[ri] + 1 > 3) ? 3 : m_tbl[ri] + 1)
                        : ((m_tbl[ri] - 1 < 0) ? 0 : m_tbl[ri] - 1);
        if (e_bc < 64'hFFFF_FFFF) e_bc++;
        if (act != bus.pred_taken_i && e_mc < 64'hFFFF_FFFF) e_mc++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model_pred_valid", 32'(bus.pred_valid_o), 32'(e_pv));
      chk("model_pred_taken", 32'(bus.pred_taken_o), 32'(e_pt));
      chk("model_branch",     32'(bus.branch_o),     32'(e_br));
      chk("model_mispredict", 32'(bus.mispredict_o), 32'(e_mp));
`ifdef BPU_STATS_EN
      chk("model_branch_cnt", bus.branch_cnt_o, e_bc[31:0]);
      chk("model_miss_cnt",   bus.miss_cnt_o,   e_mc[31:0]);
`endif
    end
  end

  // Stimulus helpers: inputs change on the falling edge, checks follow the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pred_valid_i  = 0; bus.pred_pc_i = '0;
    bus.res_valid_i   = 0; bus.res_pc_i  = '0; bus.branchType_i = 3'd0;
    bus.zero_i        = 0; bus.resultBit31_i = 0; bus.pred_taken_i = 0;
  endtask

  task automatic predict(input logic [31:0] pc);
    idle_inputs();
    bus.pred_valid_i = 1; bus.pred_pc_i = pc;
    tick();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] t,
                         input logic z, input logic n, input logic pt);
    idle_inputs();
    bus.res_valid_i = 1; bus.res_pc_i = pc; bus.branchType_i = t;
    bus.zero_i = z; bus.resultBit31_i = n; bus.pred_taken_i = pt;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Taken truth table per type, bit index = {zero_i, resultBit31_i}
  logic [3:0] tt [8];

  initial begin
    tt[0] = 4'b0000; tt[1] = 4'b1100; tt[2] = 4'b0011; tt[3] = 4'b1110;
    tt[4] = 4'b1010; tt[5] = 4'b0001; tt[6] = 4'b0101; tt[7] = 4'b0000;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    tick();
    rst = 0;
    chk("rst_pred_valid", 32'(bus.pred_valid_o), 0);
    chk("rst_pred_taken", 32'(bus.pred_taken_o), 0);
    chk("rst_branch",     32'(bus.branch_o), 0);
    chk("rst_mispredict", 32'(bus.mispredict_o), 0);

    predict(32'h0);  chk("init_pv_0", 32'(bus.pred_valid_o), 1); chk("init_pt_0", 32'(bus.pred_taken_o), 0);
    predict(32'h4);  chk("init_pt_4", 32'(bus.pred_taken_o), 0);
    predict(32'hFC); chk("init_pt_fc", 32'(bus.pred_taken_o), 0);
    idle_inputs(); tick();
    chk("idle_pv", 32'(bus.pred_valid_o), 0);

    // Saturation up and down
    for (int i = 0; i < 4; i++) resolve(32'h40, 3'd1, 1, 0, 0);
    predict(32'h40); chk("sat_hi_pt", 32'(bus.pred_taken_o), 1);
    resolve(32'h40, 3'd1, 0, 0, 1);
    resolve(32'h40, 3'd1, 0, 0, 1);
    predict(32'h40); chk("dec_to_01_pt", 32'(bus.pred_taken_o), 0);
    resolve(32'h40, 3'd1, 0, 0, 0);
    resolve(32'h40, 3'd1, 0, 0, 0);
    resolve(32'h40, 3'd1, 1, 0, 0);
    predict(32'h40); chk("no_wrap_pt_01", 32'(bus.pred_taken_o), 0);
    resolve(32'h40, 3'd1, 1, 0, 0);
    predict(32'h40); chk("no_wrap_pt_10", 32'(bus.pred_taken_o), 1);

    // Branch-type truth table
    for (int t = 0; t < 8; t++) begin
      for (int zn = 0; zn < 4; zn++) begin
        logic [3:0] row;
        row = tt[t];
        resolve(32'h100 + 32'(t * 4), 3'(t), zn[1], zn[0], 0);
        chk($sformatf("tt_branch_t%0d_zn%0d", t, zn), 32'(bus.branch_o), 32'(row[zn]));
        chk($sformatf("tt_misp_t%0d_zn%0d", t, zn), 32'(bus.mispredict_o), 32'(row[zn]));
      end
    end

    // Mispredict flag
    resolve(32'h200, 3'd2, 1, 0, 1);
    chk("misp_bne_branch", 32'(bus.branch_o), 0);
    chk("misp_bne_flag",   32'(bus.mispredict_o), 1);
    resolve(32'h204, 3'd4, 0, 1, 1);
    chk("misp_bltz_branch", 32'(bus.branch_o), 1);
    chk("misp_bltz_flag",   32'(bus.mispredict_o), 0);

    // Same-index collision returns the old value, update still commits
    do_reset();
    idle_inputs();
    bus.pred_valid_i = 1; bus.pred_pc_i = 32'h10;
    bus.res_valid_i = 1; bus.res_pc_i = 32'h10; bus.branchType_i = 3'd1; bus.zero_i = 1;
    tick();
    chk("collide_old_pt", 32'(bus.pred_taken_o), 0);
    chk("collide_branch", 32'(bus.branch_o), 1);
    predict(32'h10); chk("collide_new_pt", 32'(bus.pred_taken_o), 1);
    predict(32'h1010); chk("alias_pt", 32'(bus.pred_taken_o), 1);

    // Reset mid-stream wins over both ports
    idle_inputs();
    bus.pred_valid_i = 1; bus.pred_pc_i = 32'h10;
    bus.res_valid_i = 1; bus.res_pc_i = 32'h10; bus.branchType_i = 3'd1; bus.zero_i = 1;
    bus.pred_taken_i = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_pv", 32'(bus.pred_valid_o), 0);
    chk("midrst_pt", 32'(bus.pred_taken_o), 0);
    chk("midrst_br", 32'(bus.branch_o), 0);
    chk("midrst_mp", 32'(bus.mispredict_o), 0);
    predict(32'h10); chk("midrst_entry_init", 32'(bus.pred_taken_o), 0);

`ifdef BPU_STATS_EN
    resolve(32'h20, 3'd1, 1, 0, 1);
    resolve(32'h24, 3'd2, 1, 0, 0);
    resolve(32'h28, 3'd6, 0, 0, 0);
    chk("stats_branch_cnt", bus.branch_cnt_o, 3);
    chk("stats_miss_cnt",   bus.miss_cnt_o, 1);
    do_reset();
    chk("stats_branch_cnt_rst", bus.branch_cnt_o, 0);
    chk("stats_miss_cnt_rst",   bus.miss_cnt_o, 0);
`endif

    // Both ports busy every cycle, few PCs so entries interact and alias
    for (int i = 0; i < 60; i++) begin
      bus.pred_valid_i  = 1'($urandom_range(0, 1));
      bus.pred_pc_i     = 32'($urandom_range(0, 3) * 4) | (32'($urandom_range(0, 1)) << 8);
      bus.res_valid_i   = 1'($urandom_range(0, 1));
      bus.res_pc_i      = 32'($urandom_range(0, 3) * 4) | (32'($urandom_range(0, 1)) << 8);
      bus.branchType_i  = 3'($urandom_range(0, 7));
      bus.zero_i        = 1'($urandom_range(0, 1));
      bus.resultBit31_i = 1'($urandom_range(0, 1));
      bus.pred_taken_i  = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
